// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters.
// Define MEM_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie.
module mem_port_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_t            r_state;
    logic              r_last;
    logic              r_we;
    logic [3:0]        r_cnt;
    logic              r_gnt0, r_gnt1;
    logic              r_rv0, r_rv1;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_any;
    logic              w_win;
    logic              w_win_we;

    always_comb begin
        w_any = r0_req | r1_req;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        w_win = !r0_req;
`else
        w_win = (r0_req && r1_req) ? ~r_last : r1_req;
`endif
        w_win_we = w_win ? r1_we : r0_we;
    end

    // r_last doubles as the owner of the transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rv0       <= 1'b0;
            r_rv1       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_rv0    <= 1'b0;
            r_rv1    <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_last      <= w_win;
                        r_gnt0      <= !w_win;
                        r_gnt1      <= w_win;
                        r_we        <= w_win_we;
                        r_mem_we    <= w_win_we;
                        r_mem_addr  <= w_win ? r1_addr : r0_addr;
                        r_mem_wdata <= w_win ? r1_wdata : r0_wdata;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_state <= IDLE;
                    end else if (READ_LATENCY == 1) begin
                        r_rv0   <= !r_last;
                        r_rv1   <= r_last;
                        r_state <= RESP;
                    end else begin
                        r_cnt   <= 4'd1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == LAT_M1) begin
                        r_rv0   <= !r_last;
                        r_rv1   <= r_last;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign r0_gnt    = r_gnt0;
    assign r1_gnt    = r_gnt1;
    assign r0_rvalid = r_rv0;
    assign r1_rvalid = r_rv1;
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

endmodule
